// File: rtl/dmem_responder.sv
// dmem_responder: target-side data memory for the core load/store port.
// One request at a time. Each request gets a response after LATENCY cycles.
//
// Ports:
//   clk, rst                         clock; asynchronous active-high reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata, req_be
//                                    store flag, byte address, data, byte enables
//   rsp_valid/rsp_ready              response handshake
//   rsp_rdata, rsp_err               load data (0 for stores and errors), error
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter     INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    // WAIT spends LATENCY-1 cycles; the counter reaching 0 ends the last one.
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          addr_err;
    logic          accept;
    logic          wr_en;
    logic [AW-1:0] idx;

    always_comb begin
        idx      = req_addr[AW+1:2];
        // Range check on the full word index so that high addresses
        // are flagged instead of aliasing into the array.
        addr_err = (req_addr[1:0] != 2'b00)
                || ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
        accept   = (state == IDLE) && req_valid && !rst;
        wr_en    = accept && req_we && !addr_err;
    end

    // Array is intentionally not reset: a committed store survives rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b]) begin
                    mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        rsp_err   <= addr_err;
                        // Load data is captured now, so later stores
                        // cannot change an in-flight response.
                        rsp_rdata <= (!req_we && !addr_err) ? mem[idx] : '0;
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (LATENCY = 3).
// Expected responses are queued at request time and checked on response.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] exp_q [$];
    logic [31:0] mem_m [256];

    dmem_responder #(
        .DEPTH_WORDS(256),
        .LATENCY    (3),
        .INIT_FILE  ("")
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    always #5 clk = ~clk;

    // Drives one request and returns #1 after its accept edge.
    task automatic do_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        int k;
        logic err;
        logic [31:0] w;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_ready_timeout: got 0, need 1");
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd256);
        if (err) begin
            exp_q.push_back({1'b1, 32'h0});
        end else if (we) begin
            w = mem_m[addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
            mem_m[addr[9:2]] = w;
            exp_q.push_back({1'b0, 32'h0});
        end else begin
            exp_q.push_back({1'b0, mem_m[addr[9:2]]});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Waits for a response, compares it, then completes the handshake.
    task automatic get_rsp(input string name);
        int k;
        logic [32:0] e;
        k = 0;
        rsp_ready = 1'b1;
        @(negedge clk);
        while (!rsp_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (!rsp_valid || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_rsp_timeout: valid=%0b queued=%0d",
                     name, rsp_valid, exp_q.size());
            rsp_ready = 1'b0;
            return;
        end
        e = exp_q.pop_front();
        if (rsp_rdata !== e[31:0]) begin
            n_fail++;
            $display("FAIL %s_rdata: got %h, need %h", name, rsp_rdata, e[31:0]);
        end
        n_checks++;
        if (rsp_err !== e[32]) begin
            n_fail++;
            $display("FAIL %s_err: got %b, need %b", name, rsp_err, e[32]);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_handshake: valid=%b ready=%b, need 0 1",
                     name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {3'b100, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b rd=%h, need 1 0 0 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        get_rsp("store_full");
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        get_rsp("load_full");
    endtask

    task automatic test_byte_mask();
        do_req(1'b1, 32'h10, 32'h000000AA, 4'b0001);
        get_rsp("store_byte");
        do_req(1'b1, 32'h10, 32'h55555555, 4'b0000);
        get_rsp("store_be0");
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        get_rsp("load_byte");
    endtask

    // Leaves the response pending so the stall test can hold it.
    task automatic test_latency();
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            n_checks++;
            if (rsp_valid !== (c == 3) || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL latency_t%0d: valid=%b ready=%b, need %0b 0",
                         c, rsp_valid, req_ready, (c == 3));
            end
        end
    endtask

    task automatic test_stall();
        logic [32:0] e;
        e = (exp_q.size() != 0) ? exp_q[0] : 33'h0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0
                || {rsp_err, rsp_rdata} !== e) begin
                n_fail++;
                $display("FAIL stall_c%0d: vld=%b rdy=%b err=%b rd=%h, need 1 0 %b %h",
                         c, rsp_valid, req_ready, rsp_err, rsp_rdata, e[32], e[31:0]);
            end
        end
        get_rsp("stall_release");
    endtask

    task automatic test_errors();
        do_req(1'b1, 32'h0, 32'h12345678, 4'hF);
        get_rsp("store_w0");
        do_req(1'b0, 32'h2, 32'h0, 4'h0);
        get_rsp("load_misaligned");
        do_req(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF);
        get_rsp("store_range");
        do_req(1'b1, 32'h1, 32'hFFFFFFFF, 4'hF);
        get_rsp("store_misaligned");
        do_req(1'b0, 32'h0, 32'h0, 4'h0);
        get_rsp("reload_w0");
        do_req(1'b1, 32'h3FC, 32'hA5A55A5A, 4'hF);
        get_rsp("store_top");
        do_req(1'b0, 32'h3FC, 32'h0, 4'h0);
        get_rsp("load_top");
    endtask

    task automatic test_reset_mid();
        do_req(1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
        rst = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b ready=%b, need 0 1",
                     rsp_valid, req_ready);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b0, 32'h20, 32'h0, 4'h0);
        get_rsp("load_after_reset");
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        rsp_ready = 1'b1;
        exp_q.push_back({1'b0, mem_m[0]});
        exp_q.push_back({1'b0, mem_m[0]});
        for (int r = 0; r < 2; r++) begin
            int k;
            logic [32:0] e;
            k = 0;
            @(negedge clk);
            while (!rsp_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h0;
            n_checks++;
            if (!rsp_valid || {rsp_err, rsp_rdata} !== e) begin
                n_fail++;
                $display("FAIL b2b_r%0d: vld=%b err=%b rd=%h, need 1 %b %h",
                         r, rsp_valid, rsp_err, rsp_rdata, e[32], e[31:0]);
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (6) @(negedge clk);
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_store_load();
        test_byte_mask();
        test_latency();
        test_stall();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
